ex_div: RTL

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_if.sv | 28 ++
 rtl/ex_div.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ex_div_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_if
// Brief    : EX-stage <-> iterative divider request/result bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_div_if #(
  parameter int DW = 32
);
  logic            start;
  logic            signed_div;
  logic [DW-1:0]   opNum1;
  logic [DW-1:0]   opNum2;
  logic            cancel;
  logic [2*DW-1:0] result;
  logic            ready;

  modport master (
    output start, signed_div, opNum1, opNum2, cancel,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, opNum1, opNum2, cancel,
    output result, ready
  );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module   : ex_div
// Brief    : Multi-cycle restoring divider (DIV/DIVU), {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div #(
  parameter int DW = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  localparam int            CW          = $clog2(DW);
  localparam logic [CW-1:0] c_last_step = CW'(DW - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_dvs;
  logic            r_signed;
  logic            r_neg1;
  logic            r_neg2;
  logic [2*DW-1:0] r_result;

  logic            w_load;
  logic            w_step;
  logic            w_finish;
  logic            w_divisor_zero;
  logic [DW-1:0]   w_mag1;
  logic [DW-1:0]   w_mag2;
  logic [DW:0]     w_rem_sh;
  logic            w_no_borrow;
  logic [DW-1:0]   w_diff;
  logic [DW-1:0]   w_rem_nxt;
  logic [DW-1:0]   w_quo_nxt;
  logic [DW-1:0]   w_quo_fix;
  logic [DW-1:0]   w_rem_fix;

  // Operand magnitudes; only signed requests are folded to absolute values.
  assign w_divisor_zero = (bus.opNum2 == '0);
  assign w_mag1 = (bus.signed_div && bus.opNum1[DW-1]) ? -bus.opNum1 : bus.opNum1;
  assign w_mag2 = (bus.signed_div && bus.opNum2[DW-1]) ? -bus.opNum2 : bus.opNum2;

  // Restoring step: the dividend register gradually becomes the quotient.
  assign w_rem_sh    = {r_rem, r_dvd[DW-1]};
  assign w_no_borrow = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff      = w_rem_sh[DW-1:0] - r_dvs;
  assign w_rem_nxt   = w_no_borrow ? w_diff : w_rem_sh[DW-1:0];
  assign w_quo_nxt   = {r_dvd[DW-2:0], w_no_borrow};

  assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = (r_signed && r_neg1)            ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    if (bus.cancel) begin
      w_state_nxt = FREE;
    end else begin
      case (r_state)
        FREE: begin
          if (bus.start) begin
            if (w_divisor_zero) begin
              w_state_nxt = BY_ZERO;
            end else begin
              w_state_nxt = ON;
              w_load      = 1'b1;
            end
          end
        end
        BY_ZERO: begin
          w_state_nxt = END;
        end
        ON: begin
          w_step = 1'b1;
          if (r_cnt == c_last_step) begin
            w_state_nxt = END;
            w_finish    = 1'b1;
          end
        end
        END: begin
          if (!bus.start) begin
            w_state_nxt = FREE;
          end
        end
        default: begin
          w_state_nxt = FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_signed <= 1'b0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_dvd    <= w_mag1;
        r_dvs    <= w_mag2;
        r_rem    <= '0;
        r_cnt    <= '0;
        r_signed <= bus.signed_div;
        r_neg1   <= bus.opNum1[DW-1];
        r_neg2   <= bus.opNum2[DW-1];
      end else if (w_step) begin
        r_dvd <= w_quo_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      // Result is captured on the last step and held only while in END.
      if (w_finish) begin
        r_result <= {w_rem_fix, w_quo_fix};
      end else if ((r_state != END) || bus.cancel) begin
        r_result <= '0;
      end
    end
  end

  assign bus.ready  = (r_state == END);
  assign bus.result = (r_state == END) ? r_result : '0;

endmodule
`default_nettype wire
